// File: rtl/adder_share_seq.sv
`default_nettype none
// ============================================================================
//  Module   : adder_share_seq (with helper sixteen_bit_std)
//  Purpose  : Two-requester round-robin sequencer around one shared 16-bit
//             ripple-carry adder; a wide add of 16*NSLICE bits is performed
//             one slice per cycle with the carry chained through a register.
//  Option   : ADDER_SHARE_SUB_EN adds sub0/sub1 ports selecting A-B mode.
//  Revision : 1.0  initial release
// ============================================================================

// 16-bit ripple-carry adder shared by both requesters
module sixteen_bit_std (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [16:0] w_c;

    assign w_c[0] = cin;

    genvar i;
    generate
        for (i = 0; i < 16; i = i + 1) begin : g_bit
            assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
            assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = w_c[16];
endmodule

module adder_share_seq #(
    parameter int NSLICE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [16*NSLICE-1:0] a0,
    input  logic [16*NSLICE-1:0] b0,
    input  logic                 cin0,
    input  logic                 req1,
    input  logic [16*NSLICE-1:0] a1,
    input  logic [16*NSLICE-1:0] b1,
    input  logic                 cin1,
`ifdef ADDER_SHARE_SUB_EN
    input  logic                 sub0,
    input  logic                 sub1,
`endif
    output logic                 ack0,
    output logic                 ack1,
    output logic [16*NSLICE-1:0] result,
    output logic                 cout,
    output logic                 busy,
    output logic                 owner
);
    localparam int W  = 16 * NSLICE;
    localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic [CW-1:0]   r_k;
    logic            r_ptr;
    logic            r_owner;
    logic [W-1:0]    r_result;
    logic            r_cout;

    logic            w_grant;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;
    logic            w_sel_cin;
    logic [15:0]     w_sum;
    logic            w_cout;

    // Both requesting: pointer decides; otherwise whichever one is asking
    assign w_grant = (req0 & req1) ? r_ptr : req1;

    // Operand selection for the grantee, including the optional subtract mode
`ifdef ADDER_SHARE_SUB_EN
    logic w_sel_sub;
    assign w_sel_sub = w_grant ? sub1 : sub0;
    assign w_sel_a   = w_grant ? a1 : a0;
    assign w_sel_b   = w_sel_sub ? ~(w_grant ? b1 : b0) : (w_grant ? b1 : b0);
    assign w_sel_cin = w_sel_sub ? 1'b1 : (w_grant ? cin1 : cin0);
`else
    assign w_sel_a   = w_grant ? a1 : a0;
    assign w_sel_b   = w_grant ? b1 : b0;
    assign w_sel_cin = w_grant ? cin1 : cin0;
`endif

    sixteen_bit_std u_add (
        .a    (r_a[16*r_k +: 16]),
        .b    (r_b[16*r_k +: 16]),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Sequencer: grant, walk the slices through the shared adder, acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_k      <= '0;
            r_ptr    <= 1'b0;
            r_owner  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req0 | req1) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_carry <= w_sel_cin;
                        r_owner <= w_grant;
                        r_k     <= '0;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_result[16*r_k +: 16] <= w_sum;
                    r_carry                <= w_cout;
                    if (r_k == CW'(NSLICE - 1)) begin
                        r_cout  <= w_cout;
                        r_state <= S_DONE;
                    end else begin
                        r_k <= r_k + CW'(1);
                    end
                end
                S_DONE: begin
                    r_ptr   <= ~r_owner;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack0   = (r_state == S_DONE) & ~r_owner;
    assign ack1   = (r_state == S_DONE) &  r_owner;
    assign busy   = (r_state != S_IDLE);
    assign owner  = r_owner;
    assign result = r_result;
    assign cout   = r_cout;
endmodule
`default_nettype wire

// File: tb/tb_adder_share_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_share_seq
//  Purpose  : Self-checking bench for adder_share_seq: transaction-level model
//             checked every cycle, directed cases plus randomized traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adder_share_seq;
    localparam int NSLICE = 2;
    localparam int W      = 16 * NSLICE;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         cin0 = 1'b0, cin1 = 1'b0;
`ifdef ADDER_SHARE_SUB_EN
    logic         sub0 = 1'b0, sub1 = 1'b0;
`endif
    logic         ack0, ack1, cout, busy, owner;
    logic [W-1:0] result;

    int errors = 0;
    int checks = 0;

    adder_share_seq #(.NSLICE(NSLICE)) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .a0     (a0),
        .b0     (b0),
        .cin0   (cin0),
        .req1   (req1),
        .a1     (a1),
        .b1     (b1),
        .cin1   (cin1),
`ifdef ADDER_SHARE_SUB_EN
        .sub0   (sub0),
        .sub1   (sub1),
`endif
        .ack0   (ack0),
        .ack1   (ack1),
        .result (result),
        .cout   (cout),
        .busy   (busy),
        .owner  (owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // phase: 0 idle, 1 computing (countdown of slice cycles), 2 acknowledging
    int           m_phase = 0;
    int           m_cnt   = 0;
    bit           m_ptr   = 0;
    bit           m_owner = 0;
    logic [W-1:0] m_res   = '0;
    bit           m_cout  = 0;
    logic [W-1:0] m_pend;
    bit           m_pcout;

    always @(posedge clk) begin
        logic         g, s;
        logic [W:0]   full;
        logic [W-1:0] oa, ob;
        logic         oc;
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_owner = 0; m_res = '0; m_cout = 0;
        end else if (m_phase == 0) begin
            if (req0 || req1) begin
                g  = (req0 && req1) ? m_ptr : req1;
                oa = g ? a1 : a0;
                ob = g ? b1 : b0;
                oc = g ? cin1 : cin0;
                s  = 1'b0;
`ifdef ADDER_SHARE_SUB_EN
                s  = g ? sub1 : sub0;
`endif
                if (s) begin
                    ob = ~ob;
                    oc = 1'b1;
                end
                full    = {1'b0, oa} + {1'b0, ob} + {{W{1'b0}}, oc};
                m_pend  = full[W-1:0];
                m_pcout = full[W];
                m_owner = g;
                m_cnt   = NSLICE;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_res   = m_pend;
                m_cout  = m_pcout;
                m_phase = 2;
            end
        end else begin
            m_ptr   = ~m_owner;
            m_phase = 0;
        end
    end

    // Compare process: DUT against model, every cycle
    always @(posedge clk) begin
        #1;
        chk("ack0",  ack0,  (m_phase == 2) && !m_owner);
        chk("ack1",  ack1,  (m_phase == 2) &&  m_owner);
        chk("busy",  busy,  m_phase != 0);
        chk("owner", owner, m_owner);
        chk("ack_exclusive", ack0 & ack1, 1'b0);
        if (m_phase != 1) begin
            chk("result", result, m_res);
            chk("cout",   cout,   m_cout);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_ack(input bit who, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(who ? ack1 : ack0) && n < 40);
        if (n >= 40) chk("ack_timeout", 0, 1);
    endtask

    task automatic wait_any(output bit who);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(ack0 || ack1) && n < 40);
        if (n >= 40) chk("ack_any_timeout", 0, 1);
        who = ack1;
    endtask

    function automatic logic [W-1:0] rnd();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v[W-1:0];
    endfunction

    initial begin
        int n;
        bit who, expw;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_result", result, 0);
        chk("reset_busy", busy, 0);
        chk("reset_owner", owner, 0);

        // inter-slice carry chain
        @(negedge clk);
        req0 = 1; a0 = 32'h0000FFFF; b0 = 32'h00000001; cin0 = 0;
        wait_ack(0, n);
        chk("t1_latency", n, NSLICE + 1);
        chk("t1_result", result, 32'h00010000);
        chk("t1_cout", cout, 0);
        @(negedge clk); req0 = 0;
        repeat (2) @(negedge clk);

        // requester 1 alone, full carry ripple
        req1 = 1; a1 = 32'hFFFFFFFF; b1 = 32'h0; cin1 = 1;
        wait_ack(1, n);
        chk("t2_result", result, 32'h0);
        chk("t2_cout", cout, 1);
        chk("t2_owner", owner, 1);
        @(negedge clk); req1 = 0;
        repeat (2) @(negedge clk);

        // simultaneous requests
        req0 = 1; a0 = 1; b0 = 2; cin0 = 0;
        req1 = 1; a1 = 3; b1 = 4; cin1 = 0;
        wait_ack(0, n);
        chk("t3_first", result, 3);
        @(negedge clk); req0 = 0;
        wait_ack(1, n);
        chk("t3_gap", n, 4);
        chk("t3_second", result, 7);
        @(negedge clk); req1 = 0;
        repeat (2) @(negedge clk);

        // round-robin with both held continuously
        req0 = 1; req1 = 1;
        expw = 0;
        for (int i = 0; i < 6; i++) begin
            wait_any(who);
            chk("rr_order", who, expw);
            expw = ~expw;
        end
        @(negedge clk); req0 = 0; req1 = 0;
        repeat (6) @(negedge clk);

        // reset during the first ADD cycle
        req0 = 1; a0 = 32'h12345678; b0 = 1; cin0 = 0;
        @(posedge clk); #1;
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ack0", ack0, 0);
        @(negedge clk); rst = 0;
        wait_ack(0, n);
        chk("rst_latency", n, NSLICE + 1);
        chk("rst_regrant", result, 32'h12345679);
        @(negedge clk); req0 = 0;
        repeat (2) @(negedge clk);

`ifdef ADDER_SHARE_SUB_EN
        req0 = 1; a0 = 5; b0 = 7; sub0 = 1; cin0 = 0;
        wait_ack(0, n);
        chk("sub_res1", result, 32'hFFFFFFFE);
        chk("sub_cout1", cout, 0);
        @(negedge clk); req0 = 0;
        repeat (2) @(negedge clk);
        req0 = 1; a0 = 7; b0 = 5;
        wait_ack(0, n);
        chk("sub_res2", result, 32'h2);
        chk("sub_cout2", cout, 1);
        @(negedge clk); req0 = 0; sub0 = 0;
        repeat (2) @(negedge clk);
`endif

        // randomized traffic, occasional reset, operand churn after grant
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) == 0);
            if (ack0) req0 = 0;
            else if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1; a0 = rnd(); b0 = rnd(); cin0 = $urandom_range(0, 1);
`ifdef ADDER_SHARE_SUB_EN
                sub0 = $urandom_range(0, 1);
`endif
            end
            if (ack1) req1 = 0;
            else if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1; a1 = rnd(); b1 = rnd(); cin1 = $urandom_range(0, 1);
`ifdef ADDER_SHARE_SUB_EN
                sub1 = $urandom_range(0, 1);
`endif
            end
            if (busy && $urandom_range(0, 3) == 0) begin
                a0 = rnd(); b1 = rnd();
            end
        end
        @(negedge clk);
        rst = 0; req0 = 0; req1 = 0;
        repeat (8) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
